// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer.
// ex_ready is registered so a memory-side stall never reaches execute combinationally.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    // Encoding is {skid_v, main_v}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    state_e     state, state_nxt;
    beat_t      main_q, skid_q, in_beat;
    logic       ready_q;
    logic [1:0] occ_q, occ_nxt;
    logic       main_v, acc, dep;
    logic       load_main_ex, load_main_skid, load_skid;

    assign in_beat = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};
    assign main_v  = state[0];
    assign acc     = ex_valid & ready_q;
    assign dep     = main_v & mem_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        load_main_ex   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = ONE;
                    load_main_ex = 1'b1;
                end
            end
            ONE: begin
                if (acc && dep) begin
                    load_main_ex = 1'b1;
                end else if (acc) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (dep) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (dep) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush empties the buffer; payload registers keep their contents.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_ex   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end

        case (state_nxt)
            ONE:     occ_nxt = 2'd1;
            TWO:     occ_nxt = 2'd2;
            default: occ_nxt = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != TWO);
            occ_q   <= occ_nxt;
        end
    end

    // NOTE: payload registers are reset because mem_wd/mem_wdata must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_ex) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

    assign ex_ready  = ready_q;
    assign mem_valid = main_v;
    assign mem_wd    = main_q.wd;
    assign mem_wreg  = main_q.wreg & main_v;
    assign mem_wdata = main_q.wdata;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus a randomized run
// compared against a queue-based model of the buffer.
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready, ex_wreg;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        mem_valid, mem_ready, mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    ex_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of accepted beats, at most two deep.
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } beat_t;

    beat_t q[$];
    beat_t last_front = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0};
    logic  m_ready = 1'b0;

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic step();
        logic  acc, dep;
        beat_t b;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ready    = 1'b0;
            last_front = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0};
        end else begin
            acc = ex_valid && m_ready;
            dep = (q.size() > 0) && mem_ready;
            if (dep) q.delete(0);
            if (flush) begin
                q.delete();
            end else if (acc) begin
                b = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata};
                q.push_back(b);
            end
            m_ready = (q.size() < 2);
        end
        if (q.size() > 0) last_front = q[0];
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
        ex_valid = v;
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        drive(1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF);
        step();
        step();
        checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL reset_ex_ready got=%b exp=0", ex_ready); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (mem_wreg !== 1'b0) begin failures++; $display("FAIL reset_mem_wreg got=%b exp=0", mem_wreg); end
        checks++; if (mem_wd !== 5'd0) begin failures++; $display("FAIL reset_mem_wd got=%0d exp=0", mem_wd); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        step();
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", ex_ready); end
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 32'h1234_5678);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", mem_valid); end
        checks++; if ({mem_wd, mem_wreg, mem_wdata} !== {5'd5, 1'b1, 32'h1234_5678})
            begin failures++; $display("FAIL single_beat got=%0d/%b/%h exp=5/1/12345678", mem_wd, mem_wreg, mem_wdata); end
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL single_occ got=%0d exp=0", occupancy); end
        checks++; if (mem_valid !== 1'b0 || mem_wreg !== 1'b0)
            begin failures++; $display("FAIL single_idle got valid=%b wreg=%b exp 0/0", mem_valid, mem_wreg); end
        checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL single_hold got=%h exp=12345678", mem_wdata); end
    endtask

    task automatic test_stream();
        mem_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, ex_ready); end
            drive(1'b1, 5'(i), 1'b1, 32'(i));
            step();
            checks++; if (mem_valid !== 1'b1 || mem_wdata !== 32'(i) || occupancy !== 2'd1)
                begin failures++; $display("FAIL stream_beat beat=%0d got v=%b d=%0d occ=%0d exp v=1 d=%0d occ=1", i, mem_valid, mem_wdata, occupancy, i); end
        end
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_stall();
        mem_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 32'hA);
        step();
        drive(1'b1, 5'd2, 1'b0, 32'hB);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        checks++; if (occupancy !== 2'd2 || ex_ready !== 1'b0)
            begin failures++; $display("FAIL stall_full got occ=%0d ready=%b exp occ=2 ready=0", occupancy, ex_ready); end
        checks++; if (mem_wdata !== 32'hA || mem_wd !== 5'd1) begin failures++; $display("FAIL stall_head got=%h exp=a", mem_wdata); end
        mem_ready = 1'b1;
        step();
        checks++; if (mem_valid !== 1'b1 || mem_wdata !== 32'hB || mem_wreg !== 1'b0)
            begin failures++; $display("FAIL stall_second got v=%b d=%h wreg=%b exp v=1 d=b wreg=0", mem_valid, mem_wdata, mem_wreg); end
        checks++; if (ex_ready !== 1'b1 || occupancy !== 2'd1)
            begin failures++; $display("FAIL stall_reopen got ready=%b occ=%0d exp ready=1 occ=1", ex_ready, occupancy); end
        step();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", mem_valid); end
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 32'h1); step();
        drive(1'b1, 5'd2, 1'b1, 32'h2); step();
        flush = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 32'hC);
        step();
        flush = 1'b0;
        checks++; if (occupancy !== 2'd0 || mem_valid !== 1'b0 || ex_ready !== 1'b1)
            begin failures++; $display("FAIL flush_full got occ=%0d v=%b ready=%b exp 0/0/1", occupancy, mem_valid, ex_ready); end
        drive(1'b1, 5'd3, 1'b1, 32'h3); step();
        flush = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 32'hC);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        checks++; if (occupancy !== 2'd0 || mem_valid !== 1'b0)
            begin failures++; $display("FAIL flush_acc got occ=%0d v=%b exp 0/0", occupancy, mem_valid); end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mem_valid !== 1'b0 || mem_wdata !== 32'h3)
                begin failures++; $display("FAIL flush_no_c cyc=%0d got v=%b d=%h exp v=0 d=3", i, mem_valid, mem_wdata); end
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        drive(1'b1, 5'd13, 1'b1, 32'hD); step();
        drive(1'b1, 5'd14, 1'b1, 32'hE); step();
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        rst = 1'b1;
        step();
        checks++; if ({ex_ready, mem_valid, mem_wreg, mem_wd, mem_wdata, occupancy} !== '0)
            begin failures++; $display("FAIL rstmid_zero got ready=%b v=%b wreg=%b wd=%0d d=%h occ=%0d exp all 0", ex_ready, mem_valid, mem_wreg, mem_wd, mem_wdata, occupancy); end
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mem_valid !== 1'b0 || occupancy !== 2'd0)
                begin failures++; $display("FAIL rstmid_stale cyc=%0d got v=%b occ=%0d exp 0/0", i, mem_valid, occupancy); end
        end
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ex_ready); end
    endtask

    task automatic test_random();
        logic        e_valid, e_wreg;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(99) < 2);
            flush     = ($urandom_range(99) < 5);
            mem_ready = ($urandom_range(99) < 60);
            drive(($urandom_range(99) < 70), 5'($urandom), 1'($urandom), $urandom);
            step();
            e_valid = (q.size() > 0);
            e_wreg  = e_valid ? q[0].wreg : 1'b0;
            e_wd    = last_front.wd;
            e_wdata = last_front.wdata;
            checks++; if (mem_valid !== e_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, mem_valid, e_valid); end
            checks++; if (mem_wreg !== e_wreg) begin failures++; $display("FAIL rand_wreg cyc=%0d got=%b exp=%b", c, mem_wreg, e_wreg); end
            checks++; if (mem_wd !== e_wd) begin failures++; $display("FAIL rand_wd cyc=%0d got=%0d exp=%0d", c, mem_wd, e_wd); end
            checks++; if (mem_wdata !== e_wdata) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, e_wdata); end
            checks++; if (occupancy !== 2'(q.size())) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
            checks++; if (ex_ready !== m_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, ex_ready, m_ready); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0);
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
